// File: rtl/skintone_pkg.sv
// Shared constants and region type for the skin-tone
// chroma cluster width pipeline.
package skintone_pkg;

  localparam int unsigned K_L   = 125;
  localparam int unsigned K_H   = 188;
  localparam int unsigned Y_MIN = 16;
  localparam int unsigned Y_MAX = 235;

  localparam int unsigned CB_WL      = 23;
  localparam int unsigned CB_WH      = 14;
  localparam int unsigned CB_WC      = 47;
  localparam int unsigned CB_SLOPE_L = 113;
  localparam int unsigned CB_SLOPE_H = 359;

  localparam int unsigned CR_WL      = 20;
  localparam int unsigned CR_WH      = 10;
  localparam int unsigned CR_WC      = 39;
  localparam int unsigned CR_SLOPE_L = 89;
  localparam int unsigned CR_SLOPE_H = 316;

  typedef enum logic [1:0] {
    REG_LOW  = 2'd0,
    REG_MID  = 2'd1,
    REG_HIGH = 2'd2
  } region_t;

endpackage

// File: rtl/skintone_width_lane.sv
// Single-channel width datapath: region/diff, slope product,
// then offset add with saturation. Three enabled stages.
module skintone_width_lane
  import skintone_pkg::*;
#(
  parameter int Y_W     = 8,
  parameter int INT_W   = 9,
  parameter int FRAC_W  = 9,
  parameter int SLOPE_W = 18,
  parameter int unsigned WL      = 23,
  parameter int unsigned WH      = 14,
  parameter int unsigned WC      = 47,
  parameter int unsigned SLOPE_L = 113,
  parameter int unsigned SLOPE_H = 359
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [Y_W-1:0]          y,
  output logic [INT_W+FRAC_W-1:0] result
);

  localparam int RES_W  = INT_W + FRAC_W;
  localparam int PROD_W = Y_W + SLOPE_W;

  region_t             reg_d;
  region_t             reg1;
  region_t             reg2;
  logic [Y_W-1:0]      diff_d;
  logic [Y_W-1:0]      diff1;
  logic [SLOPE_W-1:0]  slope;
  logic [PROD_W-1:0]   prod_d;
  logic [PROD_W-1:0]   prod2;
  logic [PROD_W:0]     sum;
  logic [RES_W-1:0]    base;
  logic [RES_W-1:0]    res_d;

  // Stage 1: classify luma and form the clamped distance
  always_comb begin
    reg_d  = REG_MID;
    diff_d = '0;
    if (y <= Y_W'(K_L)) begin
      reg_d = REG_LOW;
      if (y > Y_W'(Y_MIN))
        diff_d = y - Y_W'(Y_MIN);
    end else if (y >= Y_W'(K_H)) begin
      reg_d = REG_HIGH;
      if (y < Y_W'(Y_MAX))
        diff_d = Y_W'(Y_MAX) - y;
    end
  end

  // Stage 2: pick the slope for the region, full-width multiply
  always_comb begin
    case (reg1)
      REG_LOW:  slope = SLOPE_W'(SLOPE_L);
      REG_HIGH: slope = SLOPE_W'(SLOPE_H);
      default:  slope = '0;
    endcase
    prod_d = PROD_W'(diff1) * PROD_W'(slope);
  end

  // Stage 3: add the region offset, saturate on overflow
  always_comb begin
    case (reg2)
      REG_LOW:  base = RES_W'(WL) << FRAC_W;
      REG_HIGH: base = RES_W'(WH) << FRAC_W;
      default:  base = RES_W'(WC) << FRAC_W;
    endcase
    sum = (PROD_W+1)'(base) + (PROD_W+1)'(prod2);
    if (reg2 != REG_LOW && reg2 != REG_HIGH)
      res_d = base;
    else if (|sum[PROD_W:RES_W])
      res_d = '1;
    else
      res_d = sum[RES_W-1:0];
  end

  // Stage registers advance together on enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg1   <= REG_LOW;
      diff1  <= '0;
      reg2   <= REG_LOW;
      prod2  <= '0;
      result <= '0;
    end else if (en) begin
      reg1   <= reg_d;
      diff1  <= diff_d;
      reg2   <= reg1;
      prod2  <= prod_d;
      result <= res_d;
    end
  end

endmodule

// File: rtl/skintone_width_calc.sv
// Dual-lane (Cb/Cr) skin-tone width pipeline with
// valid/ready handshake and tag passthrough.
module skintone_width_calc
  import skintone_pkg::*;
#(
  parameter int Y_W     = 8,
  parameter int INT_W   = 9,
  parameter int FRAC_W  = 9,
  parameter int SLOPE_W = 18,
  parameter int TAG_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Y_W-1:0]          y_value,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [INT_W+FRAC_W-1:0] width_cb_result,
  output logic [INT_W+FRAC_W-1:0] width_cr_result,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic             en;
  logic             v1;
  logic             v2;
  logic             v3;
  logic [TAG_W-1:0] t1;
  logic [TAG_W-1:0] t2;
  logic [TAG_W-1:0] t3;

  assign en        = out_ready | ~v3;
  assign in_ready  = en;
  assign out_valid = v3;
  assign out_tag   = t3;

  // Valid and tag shift in lockstep with the lane datapaths
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      t1 <= '0;
      t2 <= '0;
      t3 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      t1 <= in_tag;
      t2 <= t1;
      t3 <= t2;
    end
  end

  skintone_width_lane #(
    .Y_W     (Y_W),
    .INT_W   (INT_W),
    .FRAC_W  (FRAC_W),
    .SLOPE_W (SLOPE_W),
    .WL      (CB_WL),
    .WH      (CB_WH),
    .WC      (CB_WC),
    .SLOPE_L (CB_SLOPE_L),
    .SLOPE_H (CB_SLOPE_H)
  ) u_cb (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .y      (y_value),
    .result (width_cb_result)
  );

  skintone_width_lane #(
    .Y_W     (Y_W),
    .INT_W   (INT_W),
    .FRAC_W  (FRAC_W),
    .SLOPE_W (SLOPE_W),
    .WL      (CR_WL),
    .WH      (CR_WH),
    .WC      (CR_WC),
    .SLOPE_L (CR_SLOPE_L),
    .SLOPE_H (CR_SLOPE_H)
  ) u_cr (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .y      (y_value),
    .result (width_cr_result)
  );

endmodule

// File: tb/tb_skintone_width_calc.sv
// Randomised self-checking bench for skintone_width_calc
// against an arithmetic reference with a scoreboard queue.
module tb_skintone_width_calc;

  logic        clk;
  logic        rst;
  logic [7:0]  y_value;
  logic [7:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] width_cb_result;
  logic [17:0] width_cr_result;
  logic [7:0]  out_tag;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    int       cb;
    int       cr;
    logic [7:0] tag;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   nout;
  logic stalled_prev;
  logic [17:0] held_cb;
  logic [17:0] held_cr;
  logic [7:0]  held_tag;

  skintone_width_calc dut (
    .clk             (clk),
    .rst             (rst),
    .y_value         (y_value),
    .in_tag          (in_tag),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .width_cb_result (width_cb_result),
    .width_cr_result (width_cr_result),
    .out_tag         (out_tag),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat18(input int x);
    return (x > 262143) ? 262143 : x;
  endfunction

  function automatic int model(input int y, input bit is_cr);
    int d;
    if (y <= 125) begin
      d = (y < 16) ? 0 : y - 16;
      return is_cr ? sat18(20 * 512 + d * 89)
                   : sat18(23 * 512 + d * 113);
    end else if (y >= 188) begin
      d = (y > 235) ? 0 : 235 - y;
      return is_cr ? sat18(10 * 512 + d * 316)
                   : sat18(14 * 512 + d * 359);
    end
    return is_cr ? 39 * 512 : 47 * 512;
  endfunction

  task automatic cycle(input logic v, input logic [7:0] y,
                       input logic [7:0] t, input logic ordy,
                       input int ecb, input int ecr);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    y_value   = y;
    in_tag    = t;
    out_ready = ordy;
    #1;
    checks++;
    if (in_ready !== (ordy | ~out_valid)) begin
      failures++;
      $display("FAIL in_ready: got %b want %b", in_ready,
               ordy | ~out_valid);
    end
    if (out_valid && stalled_prev) begin
      checks++;
      if (width_cb_result !== held_cb ||
          width_cr_result !== held_cr ||
          out_tag !== held_tag) begin
        failures++;
        $display("FAIL hold: got %0d/%0d/%0d want %0d/%0d/%0d",
                 width_cb_result, width_cr_result, out_tag,
                 held_cb, held_cr, held_tag);
      end
    end
    stalled_prev = out_valid && !ordy;
    held_cb  = width_cb_result;
    held_cr  = width_cr_result;
    held_tag = out_tag;
    if (out_valid && ordy) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: got cb=%0d tag=%0d want none",
                 width_cb_result, out_tag);
      end else begin
        e = q.pop_front();
        nout++;
        if (width_cb_result !== 18'(e.cb) ||
            width_cr_result !== 18'(e.cr) ||
            out_tag !== e.tag) begin
          failures++;
          $display("FAIL result: got %0d/%0d/%0d want %0d/%0d/%0d",
                   width_cb_result, width_cr_result, out_tag,
                   e.cb, e.cr, e.tag);
        end
      end
    end
    if (v && in_ready) q.push_back('{ecb, ecr, t});
  endtask

  task automatic send(input logic [7:0] y, input logic [7:0] t,
                      input logic ordy);
    cycle(1'b1, y, t, ordy, model(int'(y), 1'b0),
          model(int'(y), 1'b1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 0, 0);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 0, 0);
  endtask

  task automatic test_reset();
    int base;
    int lat;
    rst = 1'b0;
    in_valid = 1'b1;
    y_value = 8'd100;
    in_tag = 8'h5a;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || width_cb_result !== 18'd0 ||
        width_cr_result !== 18'd0 || out_tag !== 8'd0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got v=%b cb=%0d cr=%0d tag=%0d rdy=%b want 0,0,0,0,1",
               out_valid, width_cb_result, width_cr_result,
               out_tag, in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    stalled_prev = 1'b0;
    send(8'd16, 8'd7, 1'b1);
    base = nout;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 0, 0);
      if (nout != base && lat == 0) lat = k;
    end
    checks++;
    if (lat != 3 || nout != base + 1) begin
      failures++;
      $display("FAIL latency: got %0d (outs %0d) want 3 (outs 1)",
               lat, nout - base);
    end
  endtask

  task automatic test_regions();
    int ys[7]  = '{16, 125, 150, 188, 235, 5, 250};
    int cbs[7] = '{11776, 24093, 24064, 24041, 7168, 11776, 7168};
    int crs[7] = '{10240, 19941, 19968, 19972, 5120, 10240, 5120};
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 8'(ys[i]), 8'(i + 16), 1'b1, cbs[i], crs[i]);
    drain();
  endtask

  task automatic test_backpressure();
    int base;
    base = nout;
    send(8'd16, 8'd1, 1'b1);
    send(8'd150, 8'd2, 1'b1);
    send(8'd235, 8'd3, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send(8'd99, 8'd9, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall: got v=%b rdy=%b want 1,0",
                 out_valid, in_ready);
      end
    end
    drain();
    checks++;
    if (nout != base + 3) begin
      failures++;
      $display("FAIL bp_count: got %0d want 3", nout - base);
    end
  endtask

  task automatic test_throughput();
    int base;
    int hits;
    base = nout;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      send(8'($urandom_range(0, 255)), 8'(i), 1'b1);
      if (i >= 3 && out_valid) hits++;
    end
    checks++;
    if (hits != 97) begin
      failures++;
      $display("FAIL throughput: got %0d want 97", hits);
    end
    drain();
    checks++;
    if (nout != base + 100) begin
      failures++;
      $display("FAIL tp_count: got %0d want 100", nout - base);
    end
  endtask

  task automatic test_random_bp();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(8'($urandom_range(0, 255)), 8'($urandom),
             1'($urandom_range(0, 1)));
      else
        cycle(1'b0, 8'd0, 8'd0, 1'($urandom_range(0, 1)), 0, 0);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    int base;
    send(8'd30, 8'd41, 1'b1);
    send(8'd140, 8'd42, 1'b1);
    send(8'd200, 8'd43, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got v=%b rdy=%b want 0,1",
               out_valid, in_ready);
    end
    q.delete();
    stalled_prev = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = nout;
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 0, 0);
    checks++;
    if (nout != base) begin
      failures++;
      $display("FAIL ghost_out: got %0d want 0", nout - base);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nout = 0;
    stalled_prev = 1'b0;
    held_cb = '0;
    held_cr = '0;
    held_tag = '0;
    rst = 1'b0;
    in_valid = 1'b0;
    y_value = '0;
    in_tag = '0;
    out_ready = 1'b1;
    test_reset();
    test_regions();
    test_backpressure();
    test_throughput();
    test_random_bp();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
